// File: rtl/cqe_write_initiator.sv
// rtl/cqe_write_initiator.sv - accepts one completion, obtains its ring offset, issues the CQE DMA write
// Three-state sequencer (IDLE -> REQ -> WR); a single completion is in flight at a time.
module cqe_write_initiator #(
  parameter int CQE_LENGTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cqm_init_finish,
  input  logic                    i_cpl_valid,
  output logic                    o_cpl_ready,
  input  logic [23:0]             iv_cpl_cq_index,
  input  logic [31:0]             iv_cpl_cq_size,
  input  logic [63:0]             iv_cpl_cq_base,
  input  logic [CQE_LENGTH*8-1:0] iv_cpl_cqe,
  output logic                    o_req_valid,
  output logic [23:0]             ov_req_cq_index,
  output logic [31:0]             ov_req_cq_size,
  input  logic                    i_resp_valid,
  input  logic [23:0]             iv_resp_cq_offset,
  output logic                    o_dma_wr_valid,
  input  logic                    i_dma_wr_ready,
  output logic [63:0]             ov_dma_wr_addr,
  output logic [11:0]             ov_dma_wr_len,
  output logic [CQE_LENGTH*8-1:0] ov_dma_wr_data,
  output logic [31:0]             ov_cqe_count,
  output logic                    o_busy
);

  localparam int DW = CQE_LENGTH * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t          state_q;
  logic [23:0]     index_q;
  logic [31:0]     size_q;
  logic [63:0]     base_q;
  logic [DW-1:0]   cqe_q;
  logic [23:0]     offset_q;
  logic [31:0]     count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      size_q   <= '0;
      base_q   <= '0;
      cqe_q    <= '0;
      offset_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cqm_init_finish && i_cpl_valid) begin
            index_q <= iv_cpl_cq_index;
            size_q  <= iv_cpl_cq_size;
            base_q  <= iv_cpl_cq_base;
            cqe_q   <= iv_cpl_cqe;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (i_resp_valid) begin
            offset_q <= iv_resp_cq_offset;
            state_q  <= WR;
          end
        end
        WR: begin
          if (i_dma_wr_ready) begin
            count_q <= count_q + 32'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request drops in the grant cycle so the offset manager cannot serve it twice.
  assign o_cpl_ready     = (state_q == IDLE) && i_cqm_init_finish && !rst;
  assign o_req_valid     = (state_q == REQ) && !i_resp_valid;
  assign o_dma_wr_valid  = (state_q == WR);
  assign o_busy          = (state_q != IDLE);

  assign ov_req_cq_index = index_q;
  assign ov_req_cq_size  = size_q;
  assign ov_dma_wr_addr  = base_q + {40'd0, offset_q};
  assign ov_dma_wr_len   = 12'(CQE_LENGTH);
  assign ov_dma_wr_data  = cqe_q;
  assign ov_cqe_count    = count_q;

endmodule
